// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with prioritised redirect selection and stall-time redirect buffering.
// Latency: an unstalled redirect loads pc on the next edge, and flush rises in the same cycle as the new pc.
// Backpressure: stall freezes pc; a redirect seen under stall is buffered and applied when stall releases.
//
// Ports:
//   clk, rst             core clock; synchronous active-high reset
//   stall                fetch stall, holds pc
//   ex_pc, imm, rs1_data execute-stage operands for branch/jal/jalr target generation
//   jump, jalr, branch, cmpr  execute-stage control-flow resolution
//   trap, trap_vec       exception/interrupt entry and its target
//   mret, mepc           trap return and its target
//   pc, pc_valid         current fetch address and its qualifier
//   flush                one-cycle pulse, aligned with pc taking a redirect target
//   misalign, misalign_addr  one-cycle report of a dropped misaligned jump/branch target
//
// Optional feature: define PC_MISALIGN_CHECK_EN to drop jump and taken-branch targets whose
// low two bits are non-zero and report them on misalign/misalign_addr. Trap and mret targets are
// never checked. With the macro undefined, misalign and misalign_addr stay at 0.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSN_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            jump,
  input  logic            jalr,
  input  logic            branch,
  input  logic            cmpr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  // BOOT: one cycle after reset with pc_valid low.
  // RUN:  normal fetch.
  // PEND: a redirect target is parked while fetch is stalled.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            flush_q, flush_d;
  logic            misalign_q;
  logic [XLEN-1:0] misalign_addr_q;

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;

  logic            redir_vld;
  logic [XLEN-1:0] redir_dat;
  logic            redir_chk;
  logic            redir_bad;
  logic            redir_take;

  // Target arithmetic wraps modulo 2^XLEN; carries are simply dropped.
  assign seq_target  = pc_q + XLEN'(INSN_BYTES);
  assign rel_target  = ex_pc + imm;
  assign jalr_sum    = rs1_data + imm;
  assign jalr_target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};

  // Fixed priority: trap > mret > jump > taken branch.
  // redir_chk marks targets that are subject to the alignment check.
  always_comb begin
    redir_vld = 1'b0;
    redir_dat = '0;
    redir_chk = 1'b0;
    if (trap) begin
      redir_vld = 1'b1;
      redir_dat = trap_vec;
    end else if (mret) begin
      redir_vld = 1'b1;
      redir_dat = mepc;
    end else if (jump) begin
      redir_vld = 1'b1;
      redir_dat = jalr ? jalr_target : rel_target;
      redir_chk = 1'b1;
    end else if (branch && cmpr) begin
      redir_vld = 1'b1;
      redir_dat = rel_target;
      redir_chk = 1'b1;
    end
  end

  // A misaligned checked target is reported instead of taken, so the cycle then behaves as if
  // there were no redirect at all. Redirects are ignored during BOOT, so nothing is reported there.
  assign redir_bad  = CHECK_EN && (state_q != ST_BOOT) && redir_vld && redir_chk &&
                      (redir_dat[1:0] != 2'b00);
  assign redir_take = redir_vld && !redir_bad;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redir_take) begin
          if (stall) begin
            pend_d  = redir_dat;
            state_d = ST_PEND;
          end else begin
            pc_d    = redir_dat;
            flush_d = 1'b1;
          end
        end else if (!stall) begin
          pc_d = seq_target;
        end
      end
      ST_PEND: begin
        if (stall) begin
          // The younger resolve supersedes whatever is parked.
          if (redir_take) begin
            pend_d = redir_dat;
          end
        end else begin
          // A redirect arriving on the release cycle wins over the parked target.
          pc_d    = redir_take ? redir_dat : pend_q;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      pend_q          <= '0;
      flush_q         <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      misalign_q <= redir_bad;
      if (redir_bad) begin
        misalign_addr_q <= redir_dat;
      end
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = (state_q != ST_BOOT);
  assign flush         = flush_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed checking of pc_unit against a behavioural reference.
// Latency: the reference advances once per clock edge and is compared 1 time unit after the edge.
// Backpressure: stall is driven randomly; buffered redirects are tracked by the reference.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] ex_pc;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        jump;
  logic        jalr;
  logic        branch;
  logic        cmpr;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        misalign;
  logic [31:0] misalign_addr;

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .INSN_BYTES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .ex_pc(ex_pc),
    .imm(imm),
    .rs1_data(rs1_data),
    .jump(jump),
    .jalr(jalr),
    .branch(branch),
    .cmpr(cmpr),
    .trap(trap),
    .trap_vec(trap_vec),
    .mret(mret),
    .mepc(mepc),
    .pc(pc),
    .pc_valid(pc_valid),
    .flush(flush),
    .misalign(misalign),
    .misalign_addr(misalign_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference state: the fetch address, whether the boot cycle is still ahead,
  // and an optional parked redirect target.
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_pend_vld;
  bit          m_boot;
  bit          m_flush;
  bit          m_mis;
  logic [31:0] m_mis_addr;

  task automatic model_reset();
    m_pc       = RV;
    m_pend     = '0;
    m_pend_vld = 0;
    m_boot     = 1;
    m_flush    = 0;
    m_mis      = 0;
    m_mis_addr = '0;
  endtask

  // Chooses the winning redirect by priority; chk marks jump/branch targets.
  task automatic pick(output bit v, output logic [31:0] t, output bit chk);
    v   = 1;
    chk = 0;
    t   = '0;
    if (trap)                t = trap_vec;
    else if (mret)           t = mepc;
    else if (jump && jalr) begin t = (rs1_data + imm) & 32'hFFFF_FFFE; chk = 1; end
    else if (jump)         begin t = ex_pc + imm; chk = 1; end
    else if (branch && cmpr) begin t = ex_pc + imm; chk = 1; end
    else                     v = 0;
  endtask

  task automatic step(input string tag);
    bit          v;
    bit          chk;
    bit          bad;
    logic [31:0] t;
    pick(v, t, chk);
    bad = 0;
`ifdef PC_MISALIGN_CHECK_EN
    bad = !m_boot && v && chk && (t[1:0] != 2'b00);
`endif
    if (bad) v = 0;
    m_flush = 0;
    m_mis   = bad;
    if (bad) m_mis_addr = t;
    if (rst) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (stall) begin
      if (v) begin
        m_pend     = t;
        m_pend_vld = 1;
      end
    end else if (v) begin
      m_pc       = t;
      m_flush    = 1;
      m_pend_vld = 0;
    end else if (m_pend_vld) begin
      m_pc       = m_pend;
      m_flush    = 1;
      m_pend_vld = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end

    @(posedge clk);
    #1;
    check_val({tag, ".pc"}, pc, m_pc);
    check_val({tag, ".pc_valid"}, 32'(pc_valid), 32'(!m_boot));
    check_val({tag, ".flush"}, 32'(flush), 32'(m_flush));
    check_val({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
`ifdef PC_MISALIGN_CHECK_EN
    if (m_mis) check_val({tag, ".misalign_addr"}, misalign_addr, m_mis_addr);
`else
    check_val({tag, ".misalign_addr"}, misalign_addr, 32'h0);
`endif
  endtask

  task automatic clear_inputs();
    rst      = 0;
    stall    = 0;
    ex_pc    = '0;
    imm      = '0;
    rs1_data = '0;
    jump     = 0;
    jalr     = 0;
    branch   = 0;
    cmpr     = 0;
    trap     = 0;
    trap_vec = '0;
    mret     = 0;
    mepc     = '0;
  endtask

  task automatic randomize_inputs();
    rst      = ($urandom_range(0, 199) == 0);
    stall    = ($urandom_range(0, 9) < 3);
    trap     = ($urandom_range(0, 19) == 0);
    mret     = ($urandom_range(0, 19) == 0);
    jump     = ($urandom_range(0, 5) == 0);
    jalr     = ($urandom_range(0, 1) == 0);
    branch   = ($urandom_range(0, 4) == 0);
    cmpr     = ($urandom_range(0, 1) == 0);
    ex_pc    = $urandom() & 32'hFFFF_FFFC;
    imm      = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
    rs1_data = $urandom();
    trap_vec = $urandom() & 32'hFFFF_FFFC;
    mepc     = $urandom() & 32'hFFFF_FFFC;
  endtask

  initial begin
    model_reset();
    clear_inputs();

    // Reset release and boot sequence.
    rst = 1;
    step("reset");
    check_val("tp_reset_pc", pc, 32'h100);
    check_val("tp_reset_valid", 32'(pc_valid), 32'h0);
    rst = 0;
    step("boot");
    check_val("tp_boot_valid", 32'(pc_valid), 32'h1);
    check_val("tp_boot_pc", pc, 32'h100);
    step("run0");
    check_val("tp_run0_pc", pc, 32'h104);

    // Taken branch with negative offset, then not-taken branch.
    branch = 1; cmpr = 1; ex_pc = 32'h200; imm = 32'hFFFF_FFF0;
    step("br_taken");
    check_val("tp_br_pc", pc, 32'h1F0);
    check_val("tp_br_flush", 32'(flush), 32'h1);
    clear_inputs();
    step("br_after");
    check_val("tp_br_flush_once", 32'(flush), 32'h0);
    branch = 1; cmpr = 0; ex_pc = 32'h200; imm = 32'hFFFF_FFF0;
    step("br_not_taken");
    check_val("tp_brnt_pc", pc, 32'h1F8);

    // jalr clears bit 0 of the sum.
    clear_inputs();
    jump = 1; jalr = 1; rs1_data = 32'h1001; imm = 32'h4;
    step("jalr");
    check_val("tp_jalr_pc", pc, 32'h1004);

    // Sequential wrap at the top of the address space.
    clear_inputs();
    trap = 1; trap_vec = 32'hFFFF_FFFC;
    step("wrap_set");
    clear_inputs();
    step("wrap");
    check_val("tp_wrap_pc", pc, 32'h0);

    // Redirects under stall: the younger branch supersedes the parked jump.
    stall = 1; jump = 1; ex_pc = 32'h300;
    step("stall_jump");
    check_val("tp_stall_hold", pc, 32'h0);
    jump = 0; branch = 1; cmpr = 1; ex_pc = 32'h400;
    step("stall_branch");
    check_val("tp_stall_noflush", 32'(flush), 32'h0);
    clear_inputs();
    step("stall_release");
    check_val("tp_release_pc", pc, 32'h400);
    check_val("tp_release_flush", 32'(flush), 32'h1);
    step("stall_after");
    check_val("tp_release_once", 32'(flush), 32'h0);

    // trap outranks a simultaneous jump.
    trap = 1; trap_vec = 32'h80; jump = 1; ex_pc = 32'h500;
    step("trap_jump");
    check_val("tp_trap_pc", pc, 32'h80);

    // Reset while a redirect is parked discards it.
    clear_inputs();
    stall = 1; jump = 1; ex_pc = 32'h300;
    step("pend_set");
    clear_inputs();
    rst = 1;
    step("pend_reset");
    check_val("tp_pend_rst_pc", pc, 32'h100);
    rst = 0;
    step("pend_boot");
    step("pend_run");
    check_val("tp_pend_discard_pc", pc, 32'h104);
    check_val("tp_pend_discard_flush", 32'(flush), 32'h0);

`ifdef PC_MISALIGN_CHECK_EN
    branch = 1; cmpr = 1; ex_pc = 32'h200; imm = 32'h2;
    step("misalign");
    check_val("tp_mis_pulse", 32'(misalign), 32'h1);
    check_val("tp_mis_addr", misalign_addr, 32'h202);
    check_val("tp_mis_pc", pc, 32'h108);
    check_val("tp_mis_flush", 32'(flush), 32'h0);
    clear_inputs();
`endif

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
